// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched instructions with their PCs.
// Flush has priority over push and pop; push while full is accepted only alongside a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o
);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s, do_pop_s;

    // Pointer and occupancy next-state.
    always_comb begin
        do_pop_s  = pop_i && (count_q != '0);
        do_push_s = push_i && ((count_q != FULL_C) || do_pop_s);
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = do_pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
            wr_ptr_d = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
            count_d  = count_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit_checker.sv
// Protocol checks for the fetch stage's instruction-memory port.
module fetch_unit_checker #(
    parameter int CW = 3
) (
    input logic          clk,
    input logic          reset_n,
    input logic          imem_rvalid,
    input logic [CW-1:0] outstanding_i
);

    rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!reset_n) imem_rvalid |-> (outstanding_i != '0)
    );

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: sequential PC generation, in-order imem requests,
// response buffering and redirect handling with stale-response dropping.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    input  logic        instr_ready
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] count_s;
    logic [CW:0]   inflight_s;
    logic          grant_s, rsp_s, drop_s, push_s, pop_s;
    fetch_entry_t  push_entry_s, head_s;

    // Slots are reserved at issue time, so a granted request always has FIFO room.
    assign inflight_s = {1'b0, outstanding_q} + {1'b0, count_s};
    assign imem_req   = reset_n && (inflight_s < DEPTH_C) && !redirect_valid;
    assign imem_addr  = fetch_pc_q;
    assign grant_s    = imem_req && imem_gnt;

    assign rsp_s        = imem_rvalid && (outstanding_q != '0);
    assign drop_s       = rsp_s && (drop_cnt_q != '0);
    assign push_s       = rsp_s && !drop_s;
    assign pop_s        = instr_valid && instr_ready;
    assign push_entry_s = '{pc: resp_pc_q, instr: imem_rdata};

    // PC, in-flight and drop bookkeeping next-state.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CW'(grant_s) - CW'(rsp_s);
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            resp_pc_d  = word_align(redirect_pc);
            drop_cnt_d = outstanding_q - CW'(rsp_s);
        end else begin
            fetch_pc_d = grant_s ? fetch_pc_q + WORD_BYTES : fetch_pc_q;
            resp_pc_d  = push_s  ? resp_pc_q + WORD_BYTES  : resp_pc_q;
            drop_cnt_d = drop_s  ? drop_cnt_q - CW'(1)     : drop_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (redirect_valid),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (count_s)
    );

    fetch_unit_checker #(
        .CW(CW)
    ) u_checker (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_rvalid   (imem_rvalid),
        .outstanding_i (outstanding_q)
    );

    assign instr_valid    = (count_s != '0);
    assign instr          = head_s.instr;
    assign instr_pc       = head_s.pc;
    assign instr_pc_plus4 = head_s.pc + WORD_BYTES;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, corner sequences and
// randomized traffic against a queue-based model of the fetch stream.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        instr_ready = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .instr_ready    (instr_ready)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
        bit          stale;
    } mem_rsp_t;

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    mem_rsp_t    memq[$];
    vec_t        vecs[10];
    int          cyc;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc, exp_fetch;
    int          model_count;
    int          min_lat = 1, max_lat = 1;
    int          grants, max_inflight;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_p4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        instr_ready    = 1'b0;
        redirect_pc    = 32'h0;
        memq.delete();
        exp_pc = 32'h0; exp_fetch = 32'h0; model_count = 0; cyc = 0;
        grants = 0; max_inflight = 0;
        repeat (2) @(posedge clk);
        #2;
        check1("reset_req", imem_req, 1'b0);
        check1("reset_valid", instr_valid, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One clock: drive inputs, sample just before the edge, advance the model.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt, input logic gnt_in);
        logic     rv, pop, grant;
        mem_rsp_t r;
        rv = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rvalid    = rv;
        imem_rdata     = rv ? memq[0].data : 32'h0;
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_gnt       = gnt_in;
        instr_ready    = rdy;
        #4;
        s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
        s_pc = instr_pc; s_p4 = instr_pc_plus4;
        check1("imem_req", imem_req, ((memq.size() + model_count) < DEPTH) && !redir);
        check1("instr_valid", instr_valid, model_count != 0);
        if (model_count != 0) begin
            check32("instr_pc", instr_pc, exp_pc);
            check32("instr", instr, mem_word(exp_pc));
            check32("instr_pc_plus4", instr_pc_plus4, exp_pc + 32'd4);
        end
        pop = (model_count != 0) && rdy && !redir;
        if (rv) begin
            r = memq.pop_front();
            if (!r.stale && !redir) model_count++;
        end
        grant = imem_req && gnt_in;
        if (grant) begin
            check32("imem_addr", imem_addr, exp_fetch);
            memq.push_back('{mem_word(imem_addr), cyc + int'($urandom_range(max_lat, min_lat)), 1'b0});
            exp_fetch = exp_fetch + 32'd4;
            grants++;
        end
        if (pop) begin
            model_count--;
            exp_pc = exp_pc + 32'd4;
        end
        if (redir) begin
            foreach (memq[i]) memq[i].stale = 1'b1;
            model_count = 0;
            exp_pc      = tgt & 32'hFFFF_FFFC;
            exp_fetch   = exp_pc;
        end
        if (memq.size() > max_inflight) max_inflight = memq.size();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        logic [31:0] t;

        // Zero-wait memory, ready high; redirect at cycle 5 coincides with a response and a pop.
        vecs[0] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0000, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0004, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};
        vecs[3] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004};
        vecs[4] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008};
        vecs[5] = '{1'b1, 1'b1, 32'h102, 1'b0, 32'h0,         1'b1, 32'h0000_000C};
        vecs[6] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0100, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0104, 1'b0, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100};
        vecs[9] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_010C, 1'b1, 32'h0000_0104};

        min_lat = 1; max_lat = 1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rdy, vecs[i].redir, vecs[i].tgt, 1'b1);
            check1("tbl_req", s_req, vecs[i].e_req);
            if (vecs[i].e_req) check32("tbl_addr", s_addr, vecs[i].e_addr);
            check1("tbl_valid", s_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) check32("tbl_pc", s_pc, vecs[i].e_pc);
        end

        // Decode stalled: exactly DEPTH requests, then retained in order.
        do_reset();
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);
        check32("stall_grants", 32'(grants), 32'd4);
        check1("stall_req_low", s_req, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check32("stall_first_pc", s_pc, 32'h0);
        repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);

        // Three-cycle memory latency with random grant.
        do_reset();
        min_lat = 3; max_lat = 3;
        repeat (80) step(1'b1, 1'b0, 32'h0, 1'($urandom_range(1, 0)));
        check1("lat3_inflight_bound", max_inflight <= DEPTH, 1'b1);
        check1("lat3_progress", exp_pc != 32'h0, 1'b1);

        // Redirect with two requests in flight.
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check32("redir_inflight", 32'(memq.size()), 32'd2);
        step(1'b0, 1'b1, 32'h0000_0102, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            found = s_valid;
        end
        check1("redir_found", found, 1'b1);
        check32("redir_pc", s_pc, 32'h0000_0100);
        check32("redir_pc4", s_p4, 32'h0000_0104);

        // Reset asserted with the FIFO full.
        do_reset();
        min_lat = 1; max_lat = 1;
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);
        check1("full_valid", s_valid, 1'b1);
        check1("full_req", s_req, 1'b0);
        reset_n = 1'b0;
        #1;
        check1("midrst_req", imem_req, 1'b0);
        check1("midrst_valid", instr_valid, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check32("restart_pc", s_pc, 32'h0);

        // Randomized traffic, including redirects near the top of the address space.
        do_reset();
        min_lat = 1; max_lat = 4;
        for (int i = 0; i < 1500; i++) begin
            t = $urandom();
            if ($urandom_range(3, 0) == 0) t = 32'hFFFF_FFF0 | (t & 32'h0000_000F);
            step(1'($urandom_range(3, 0) != 0), 1'($urandom_range(24, 0) == 0), t,
                 1'($urandom_range(9, 0) < 7));
        end
        check1("rand_inflight_bound", max_inflight <= DEPTH, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
